// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_pkg
//  Description : Shared types and constants for the text_console block.
//                Holds the FSM state encoding, the post-decode action
//                encoding, the ASCII control codes, the printable range
//                and the FIFO word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package text_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ADVANCE   = 3'd5
    } state_t;

    // What ADVANCE should do with the cursor once the current byte is handled
    typedef enum logic [1:0] {
        ACT_DRAW = 2'd0,
        ACT_CR   = 2'd1,
        ACT_LF   = 2'd2,
        ACT_BS   = 2'd3
    } act_t;

    localparam logic [7:0] CHR_CR        = 8'h0D;
    localparam logic [7:0] CHR_LF        = 8'h0A;
    localparam logic [7:0] CHR_BS        = 8'h08;
    localparam logic [7:0] CHR_ERASE     = 8'h7F;  // solid block glyph
    localparam logic [7:0] CHR_PRINT_MIN = 8'h20;
    localparam logic [7:0] CHR_PRINT_MAX = 8'h7E;

    // FIFO word: {char[7:0], colour[2:0]}
    localparam int FIFO_W = 11;

endpackage : text_console_pkg
`default_nettype wire

// File: rtl/text_console_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : char_fifo
//  Description : Synchronous FIFO, DEPTH entries of WIDTH bits, with
//                full/empty flags and a zero-latency head output.
//  Ports       : clk50, reset (async, active-high)
//                i_push/i_din  - write side (ignored when full)
//                i_pop         - read side (ignored when empty)
//                o_dout        - current head entry
//                o_full/o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
module char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_wr_en = i_push & ~o_full;
    assign w_rd_en = i_pop  & ~o_empty;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone
    always_ff @(posedge clk50) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
    end

endmodule : char_fifo
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : Character-stream front end for the text GPU. Buffers
//                ASCII bytes, tracks a text cursor and issues one drawChar
//                command per printable byte, handling CR, LF and line/screen
//                wrap. Optional macro TEXT_CONSOLE_BS_EN enables destructive
//                backspace (0x08); without it 0x08 is discarded.
//  Ports       : clk50, reset (async, active-high)
//                in_valid/in_char/in_color/in_ready - byte input port
//                gpu_done                            - GPU idle handshake
//                gpu_draw_char, gpu_x, gpu_y, gpu_char, gpu_color - command
//                gpu_draw_box, gpu_x_max, gpu_y_max  - tied to 0
//                cursor_col/cursor_row, busy         - status
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console
    import text_console_pkg::*;
#(
    parameter int COLS       = 26,
    parameter int ROWS       = 13,
    parameter int CELL_W     = 6,
    parameter int CELL_H     = 9,
    parameter int X_ORIGIN   = 0,
    parameter int Y_ORIGIN   = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    input  logic [2:0] in_color,
    output logic       in_ready,
    input  logic       gpu_done,
    output logic       gpu_draw_char,
    output logic       gpu_draw_box,
    output logic [7:0] gpu_x,
    output logic [8:0] gpu_y,
    output logic [7:0] gpu_x_max,
    output logic [8:0] gpu_y_max,
    output logic [6:0] gpu_char,
    output logic [2:0] gpu_color,
    output logic [4:0] cursor_col,
    output logic [3:0] cursor_row,
    output logic       busy
);

`ifdef TEXT_CONSOLE_BS_EN
    localparam bit c_BS_EN = 1'b1;
`else
    localparam bit c_BS_EN = 1'b0;
`endif

    localparam logic [7:0] c_X0       = 8'(X_ORIGIN);
    localparam logic [8:0] c_Y0       = 9'(Y_ORIGIN);
    localparam logic [7:0] c_CELL_W   = 8'(CELL_W);
    localparam logic [8:0] c_CELL_H   = 9'(CELL_H);
    localparam logic [4:0] c_COL_LAST = 5'(COLS - 1);
    localparam logic [3:0] c_ROW_LAST = 4'(ROWS - 1);

    state_t            r_state;
    state_t            w_next;
    act_t              r_act;
    logic [7:0]        r_cur_char;
    logic [2:0]        r_cur_color;
    logic [4:0]        r_col;
    logic [3:0]        r_row;
    logic [7:0]        r_x;
    logic [8:0]        r_y;
    logic [6:0]        r_gchar;
    logic [2:0]        r_gcolor;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [FIFO_W-1:0] w_head;
    logic              w_printable;
    logic              w_is_crlf;
    logic              w_bs_ok;

    assign w_push = in_valid & ~w_full;

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk50   (clk50),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   ({in_char, in_color}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_printable = (r_cur_char >= CHR_PRINT_MIN) && (r_cur_char <= CHR_PRINT_MAX);
    assign w_is_crlf   = (r_cur_char == CHR_CR) || (r_cur_char == CHR_LF);
    // Backspace at column 0 has nothing to erase and is dropped
    assign w_bs_ok     = c_BS_EN && (r_cur_char == CHR_BS) && (r_col != 5'd0);

    // State register
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (!w_empty) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_printable || w_bs_ok) w_next = ST_ISSUE;
                else if (w_is_crlf)         w_next = ST_ADVANCE;
                else                        w_next = ST_IDLE;
            end
            ST_ISSUE:     if (gpu_done)  w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!gpu_done) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (gpu_done)  w_next = ST_ADVANCE;
            ST_ADVANCE:   w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_pop         = (r_state == ST_IDLE) && !w_empty;
        gpu_draw_char = (r_state == ST_ISSUE) && gpu_done;
        busy          = (r_state != ST_IDLE) || !w_empty;
    end

    // Datapath: popped byte, draw command registers and running cursor.
    // gpu_x/gpu_y track the cursor cell by stepping, so no multiply is needed.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_cur_char  <= 8'h00;
            r_cur_color <= 3'b000;
            r_act       <= ACT_DRAW;
            r_col       <= 5'd0;
            r_row       <= 4'd0;
            r_x         <= c_X0;
            r_y         <= c_Y0;
            r_gchar     <= 7'h00;
            r_gcolor    <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) {r_cur_char, r_cur_color} <= w_head;
                end
                ST_DECODE: begin
                    if (w_printable) begin
                        r_gchar  <= r_cur_char[6:0];
                        r_gcolor <= r_cur_color;
                        r_act    <= ACT_DRAW;
                    end else if (w_bs_ok) begin
                        // Step back first so the erase block lands on the
                        // previous cell, which then stays the cursor cell
                        r_col    <= r_col - 5'd1;
                        r_x      <= r_x - c_CELL_W;
                        r_gchar  <= CHR_ERASE[6:0];
                        r_gcolor <= 3'b000;
                        r_act    <= ACT_BS;
                    end else if (r_cur_char == CHR_CR) begin
                        r_act    <= ACT_CR;
                    end else if (r_cur_char == CHR_LF) begin
                        r_act    <= ACT_LF;
                    end
                end
                ST_ADVANCE: begin
                    if ((r_act == ACT_CR) || (r_act == ACT_LF) ||
                        ((r_act == ACT_DRAW) && (r_col == c_COL_LAST))) begin
                        r_col <= 5'd0;
                        r_x   <= c_X0;
                    end else if (r_act == ACT_DRAW) begin
                        r_col <= r_col + 5'd1;
                        r_x   <= r_x + c_CELL_W;
                    end
                    // New line: LF, or a draw in the last column; no scrolling
                    if ((r_act == ACT_LF) ||
                        ((r_act == ACT_DRAW) && (r_col == c_COL_LAST))) begin
                        if (r_row == c_ROW_LAST) begin
                            r_row <= 4'd0;
                            r_y   <= c_Y0;
                        end else begin
                            r_row <= r_row + 4'd1;
                            r_y   <= r_y + c_CELL_H;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = ~w_full;
    assign gpu_draw_box = 1'b0;
    assign gpu_x_max    = 8'd0;
    assign gpu_y_max    = 9'd0;
    assign gpu_x        = r_x;
    assign gpu_y        = r_y;
    assign gpu_char     = r_gchar;
    assign gpu_color    = r_gcolor;
    assign cursor_col   = r_col;
    assign cursor_row   = r_row;

endmodule : text_console
`default_nettype wire
